// File: rtl/spi_cmd_decoder.sv
// SPI slave command decoder for the slot-machine reel/credit logic.
// Decodes MSB-first command frames and streams a status word back on sdo_o.
module spi_cmd_decoder #(
    parameter int unsigned FRAME_W     = 16,
    parameter int unsigned OP_W        = 4,
    parameter int unsigned NUM_REELS   = 3,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned NUM_SYMBOLS = 10,
    parameter int unsigned CREDIT_W    = 12
) (
    input  logic                       sclk_i,
    input  logic                       reset_ni,
    input  logic                       cs_i,
    input  logic                       sdi_i,
    input  logic                       spin_done_i,
    output logic                       sdo_o,
    output logic [NUM_REELS*IDX_W-1:0] reel_idx_o,
    output logic                       start_spin_o,
    output logic [CREDIT_W-1:0]        win_credits_o,
    output logic                       is_win_o,
    output logic [CREDIT_W-1:0]        total_credits_o,
    output logic                       is_total_o,
    output logic                       busy_o,
    output logic                       cmd_err_o,
    output logic                       frame_tgl_o
);
    localparam int unsigned CNT_W  = $clog2(FRAME_W + 1);
    localparam int unsigned SEL_W  = $clog2(FRAME_W);
    localparam int unsigned ACC_W  = FRAME_W - OP_W - 4;
    localparam int unsigned REEL_W = NUM_REELS * IDX_W;

    localparam logic [OP_W-1:0]  OpSpin  = OP_W'(1);
    localparam logic [OP_W-1:0]  OpWin   = OP_W'(2);
    localparam logic [OP_W-1:0]  OpTotal = OP_W'(3);
    localparam logic [OP_W-1:0]  OpClear = {OP_W{1'b1}};
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(FRAME_W - 1);

    logic [CNT_W-1:0]   bit_cnt_q;
    logic [FRAME_W-2:0] rx_q;

    logic [REEL_W-1:0]   reel_q, reel_d;
    logic [CREDIT_W-1:0] win_q, win_d, total_q, total_d;
    logic [OP_W-1:0]     last_op_q, last_op_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic start_q, start_d, is_win_q, is_win_d, is_total_q, is_total_d;
    logic busy_q, busy_d, err_q, err_d, tgl_q, tgl_d;

    logic [FRAME_W-1:0] rx_word;
    logic [OP_W-1:0]    op;
    logic               fire, reels_ok, accept, spin_acc;
    logic [FRAME_W-1:0] status;
    logic [SEL_W-1:0]   sel;

    // cs high clears only the shifter; the decoded state lives in the block below.
    always_ff @(posedge sclk_i or negedge reset_ni or posedge cs_i) begin
        if (!reset_ni) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
        end else if (cs_i) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
        end else if (bit_cnt_q < CntFull) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            rx_q      <= {rx_q[FRAME_W-3:0], sdi_i};
        end
    end

    always_comb begin
        rx_word    = {rx_q, sdi_i};
        op         = rx_word[FRAME_W-1 -: OP_W];
        fire       = !cs_i && (bit_cnt_q == CntLast);
        reels_ok   = 1'b1;
        for (int k = 0; k < int'(NUM_REELS); k++) begin
            if (32'(rx_word[k*IDX_W +: IDX_W]) >= NUM_SYMBOLS) begin
                reels_ok = 1'b0;
            end
        end
        reel_d     = reel_q;
        win_d      = win_q;
        total_d    = total_q;
        last_op_d  = last_op_q;
        acc_d      = acc_q;
        start_d    = start_q;
        is_win_d   = is_win_q;
        is_total_d = is_total_q;
        err_d      = err_q;
        tgl_d      = tgl_q;
        accept     = 1'b0;
        spin_acc   = 1'b0;
        if (fire) begin
            last_op_d = op;
            accept    = 1'b1;
            case (op)
                OpSpin: begin
                    if (!busy_q && reels_ok) begin
                        reel_d     = rx_word[REEL_W-1:0];
                        start_d    = 1'b1;
                        is_win_d   = 1'b0;
                        is_total_d = 1'b0;
                        spin_acc   = 1'b1;
                    end else begin
                        accept = 1'b0;
                    end
                end
                OpWin: begin
                    win_d      = rx_word[CREDIT_W-1:0];
                    is_win_d   = 1'b1;
                    start_d    = 1'b0;
                    is_total_d = 1'b0;
                end
                OpTotal: begin
                    total_d    = rx_word[CREDIT_W-1:0];
                    is_total_d = 1'b1;
                    start_d    = 1'b0;
                    is_win_d   = 1'b0;
                end
                OpClear: begin
                    start_d    = 1'b0;
                    is_win_d   = 1'b0;
                    is_total_d = 1'b0;
                    err_d      = 1'b0;
                end
                default: accept = 1'b0;
            endcase
            if (accept) begin
                acc_d = acc_q + ACC_W'(1);
                tgl_d = ~tgl_q;
            end else begin
                err_d = 1'b1;
            end
        end
        // A SPIN accepted on the spin_done edge takes priority over the clear.
        if (spin_acc) begin
            busy_d = 1'b1;
        end else if (spin_done_i) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    always_ff @(posedge sclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            reel_q     <= '0;
            win_q      <= '0;
            total_q    <= '0;
            last_op_q  <= '0;
            acc_q      <= '0;
            start_q    <= 1'b0;
            is_win_q   <= 1'b0;
            is_total_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            tgl_q      <= 1'b0;
        end else begin
            reel_q     <= reel_d;
            win_q      <= win_d;
            total_q    <= total_d;
            last_op_q  <= last_op_d;
            acc_q      <= acc_d;
            start_q    <= start_d;
            is_win_q   <= is_win_d;
            is_total_q <= is_total_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            tgl_q      <= tgl_d;
        end
    end

    always_comb begin
        status = {last_op_q, busy_q, err_q, 2'b00, acc_q};
        sel    = SEL_W'(CntLast - bit_cnt_q);
        sdo_o  = 1'b0;
        if (!cs_i && (bit_cnt_q < CntFull)) begin
            sdo_o = status[sel];
        end
    end

    assign reel_idx_o      = reel_q;
    assign start_spin_o    = start_q;
    assign win_credits_o   = win_q;
    assign is_win_o        = is_win_q;
    assign total_credits_o = total_q;
    assign is_total_o      = is_total_q;
    assign busy_o          = busy_q;
    assign cmd_err_o       = err_q;
    assign frame_tgl_o     = tgl_q;

endmodule
